// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if
// Data-bus bundle between the MEM pipeline stage and the data memory.
// The stage issues one request at a time and holds it until it is granted.
// Load data comes back later, qualified by dbus_rvalid_i.
//
// Signals (direction as seen from the stage, i.e. the master):
//   dbus_req_o     out  request valid
//   dbus_we_o      out  1 = store, 0 = load
//   dbus_addr_o    out  word-aligned byte address
//   dbus_be_o      out  byte enables for the addressed word
//   dbus_wdata_o   out  store data, replicated across the byte lanes
//   dbus_gnt_i     in   request accepted this cycle
//   dbus_rvalid_i  in   load data valid this cycle
//   dbus_rdata_i   in   load data (whole word)
// ---------------------------------------------------------------------------
interface mem_stage_if;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_gnt_i;
    logic        dbus_rvalid_i;
    logic [31:0] dbus_rdata_i;

    modport master (
        output dbus_req_o,
        output dbus_we_o,
        output dbus_addr_o,
        output dbus_be_o,
        output dbus_wdata_o,
        input  dbus_gnt_i,
        input  dbus_rvalid_i,
        input  dbus_rdata_i
    );

    modport slave (
        input  dbus_req_o,
        input  dbus_we_o,
        input  dbus_addr_o,
        input  dbus_be_o,
        input  dbus_wdata_o,
        output dbus_gnt_i,
        output dbus_rvalid_i,
        output dbus_rdata_i
    );
endinterface

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// MEM pipeline stage. It issues loads and stores on the data bus and formats
// returned load data (lane select plus sign/zero extension). It also stalls
// the pipeline while a bus transaction is in flight. Instructions that do
// not access memory pass straight through with no added latency.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   ex_*_i              instruction from EX: valid, result/address, dest reg,
//                       load/store flags, access size, unsigned flag, store data
//   dbus                mem_stage_if.master data-bus bundle
//   mem_op_c_o          result to MEM/WB (load data or pass-through ex_op_c_i)
//   mem_reg_waddr_o     destination register to MEM/WB (0 when no instruction)
//   mem_stall_o         freeze upstream stages and MEM/WB
//   mem_misalign_o      misaligned access detected (optional checker only)
//
// Configuration:
//   MEM_MISALIGN_CHK_EN  when defined, a misaligned half or word access is not
//                        issued. mem_misalign_o flags it for one cycle instead.
//                        When undefined, mem_misalign_o is tied to 0 and the
//                        address bits below the access size are ignored.
// ---------------------------------------------------------------------------
module mem_stage (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        ex_valid_i,
    input  logic [31:0] ex_op_c_i,
    input  logic [4:0]  ex_reg_waddr_i,
    input  logic        ex_mem_rd_i,
    input  logic        ex_mem_wr_i,
    input  logic [1:0]  ex_mem_size_i,
    input  logic        ex_mem_unsigned_i,
    input  logic [31:0] ex_mem_wdata_i,

    mem_stage_if.master dbus,

    output logic [31:0] mem_op_c_o,
    output logic [4:0]  mem_reg_waddr_o,
    output logic        mem_stall_o,
    output logic        mem_misalign_o
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t      state_q, state_d;

    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        uns_q;

    logic        access;
    logic        is_load;
    logic        misalign_raw;

    logic        req_int;
    logic        stall_int;
    logic        misalign_int;
    logic        load_accept;
    logic        rsp_valid;

    logic        req_out;
    logic        misalign_out;
    logic [3:0]  be_raw;
    logic [31:0] wdata_raw;
    logic [31:0] load_data;

    // Decode the incoming instruction. When a load flag and a store flag are
    // both set, the access is treated as a load.
    always_comb begin
        access  = ex_valid_i & (ex_mem_rd_i | ex_mem_wr_i);
        is_load = ex_mem_rd_i;
`ifdef MEM_MISALIGN_CHK_EN
        misalign_raw = access &
                       (((ex_mem_size_i == 2'b01) & ex_op_c_i[0]) |
                        (ex_mem_size_i[1] & (ex_op_c_i[1:0] != 2'b00)));
`else
        misalign_raw = 1'b0;
`endif
    end

    // State register. A reset abandons any outstanding load. A late rvalid
    // that arrives after reset is then seen in IDLE, where it is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Load attributes are captured when the load is granted. While waiting
    // for rvalid, EX may change, so the returned data is formatted only from
    // these copies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q  <= 2'b00;
            size_q <= 2'b00;
            uns_q  <= 1'b0;
        end else if (load_accept) begin
            off_q  <= ex_op_c_i[1:0];
            size_q <= ex_mem_size_i;
            uns_q  <= ex_mem_unsigned_i;
        end
    end

    // Next-state and control logic. In IDLE, a request is raised in the same
    // cycle the instruction arrives.
    // A store completes on its grant.
    // A load stalls until its data returns, even in the grant cycle, because
    // the result is not yet available.
    // In WAIT, no new request is issued, so at most one transaction is
    // outstanding.
    always_comb begin
        state_d      = state_q;
        req_int      = 1'b0;
        stall_int    = 1'b0;
        misalign_int = 1'b0;
        load_accept  = 1'b0;
        rsp_valid    = 1'b0;

        case (state_q)
            IDLE: begin
                if (access) begin
                    if (misalign_raw) begin
                        misalign_int = 1'b1;
                    end else begin
                        req_int = 1'b1;
                        if (is_load) begin
                            stall_int = 1'b1;
                            if (dbus.dbus_gnt_i) begin
                                load_accept = 1'b1;
                                state_d     = WAIT;
                            end
                        end else begin
                            stall_int = ~dbus.dbus_gnt_i;
                        end
                    end
                end
            end
            WAIT: begin
                stall_int = ~dbus.dbus_rvalid_i;
                if (dbus.dbus_rvalid_i) begin
                    rsp_valid = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Byte enables and store-data replication come straight from the EX
    // inputs. Upstream is frozen while the request is ungranted, so these
    // values stay stable until the grant.
    always_comb begin
        case (ex_mem_size_i)
            2'b00: begin
                be_raw    = 4'b0001 << ex_op_c_i[1:0];
                wdata_raw = {4{ex_mem_wdata_i[7:0]}};
            end
            2'b01: begin
                be_raw    = 4'b0011 << {ex_op_c_i[1], 1'b0};
                wdata_raw = {2{ex_mem_wdata_i[15:0]}};
            end
            default: begin
                be_raw    = 4'b1111;
                wdata_raw = ex_mem_wdata_i;
            end
        endcase
    end

    // Bus outputs are forced to 0 while no request is active, and also while
    // reset is asserted.
    always_comb begin
        req_out           = rst_n & req_int;
        misalign_out      = rst_n & misalign_int;
        dbus.dbus_req_o   = req_out;
        dbus.dbus_we_o    = req_out & ~is_load;
        dbus.dbus_addr_o  = req_out ? {ex_op_c_i[31:2], 2'b00} : 32'h0;
        dbus.dbus_be_o    = req_out ? be_raw : 4'b0000;
        dbus.dbus_wdata_o = req_out ? wdata_raw : 32'h0;
        mem_stall_o       = rst_n & stall_int;
        mem_misalign_o    = misalign_out;
    end

    // Select the addressed lane of the returned word, then extend it to
    // 32 bits. A halfword access uses only offset bit 1.
    always_comb begin
        load_data = dbus.dbus_rdata_i;
        case (size_q)
            2'b00: begin
                case (off_q)
                    2'b00:   load_data = {{24{~uns_q & dbus.dbus_rdata_i[7]}},  dbus.dbus_rdata_i[7:0]};
                    2'b01:   load_data = {{24{~uns_q & dbus.dbus_rdata_i[15]}}, dbus.dbus_rdata_i[15:8]};
                    2'b10:   load_data = {{24{~uns_q & dbus.dbus_rdata_i[23]}}, dbus.dbus_rdata_i[23:16]};
                    default: load_data = {{24{~uns_q & dbus.dbus_rdata_i[31]}}, dbus.dbus_rdata_i[31:24]};
                endcase
            end
            2'b01: begin
                if (off_q[1]) begin
                    load_data = {{16{~uns_q & dbus.dbus_rdata_i[31]}}, dbus.dbus_rdata_i[31:16]};
                end else begin
                    load_data = {{16{~uns_q & dbus.dbus_rdata_i[15]}}, dbus.dbus_rdata_i[15:0]};
                end
            end
            default: begin
                load_data = dbus.dbus_rdata_i;
            end
        endcase
    end

    // Results toward MEM/WB. Load data replaces the EX result only in the
    // cycle it returns. A misaligned access that is dropped does not write
    // its destination register.
    always_comb begin
        mem_op_c_o      = rsp_valid ? load_data : ex_op_c_i;
        mem_reg_waddr_o = (ex_valid_i & ~misalign_out) ? ex_reg_waddr_i : 5'd0;
    end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
// Self-checking bench for mem_stage. A transaction-level reference model
// tracks the single outstanding load and predicts every output on every
// cycle. Directed scenarios pin the model to hand-computed values. A
// randomized phase then exercises protocol, reset, and formatting corners.
// ---------------------------------------------------------------------------
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        ex_valid_i;
    logic [31:0] ex_op_c_i;
    logic [4:0]  ex_reg_waddr_i;
    logic        ex_mem_rd_i;
    logic        ex_mem_wr_i;
    logic [1:0]  ex_mem_size_i;
    logic        ex_mem_unsigned_i;
    logic [31:0] ex_mem_wdata_i;
    logic [31:0] mem_op_c_o;
    logic [4:0]  mem_reg_waddr_o;
    logic        mem_stall_o;
    logic        mem_misalign_o;

    int compared = 0;
    int mismatched = 0;

    // Reference-model state: at most one load awaiting its data.
    bit pend = 1'b0;
    int p_start = 0;
    int p_nbytes = 4;
    bit p_uns = 1'b0;

    mem_stage_if bus ();

    mem_stage dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ex_valid_i        (ex_valid_i),
        .ex_op_c_i         (ex_op_c_i),
        .ex_reg_waddr_i    (ex_reg_waddr_i),
        .ex_mem_rd_i       (ex_mem_rd_i),
        .ex_mem_wr_i       (ex_mem_wr_i),
        .ex_mem_size_i     (ex_mem_size_i),
        .ex_mem_unsigned_i (ex_mem_unsigned_i),
        .ex_mem_wdata_i    (ex_mem_wdata_i),
        .dbus              (bus.master),
        .mem_op_c_o        (mem_op_c_o),
        .mem_reg_waddr_o   (mem_reg_waddr_o),
        .mem_stall_o       (mem_stall_o),
        .mem_misalign_o    (mem_misalign_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic rd, input logic wr,
                                 input logic [1:0] size, input logic uns,
                                 input logic [31:0] opc, input logic [31:0] wdata,
                                 input logic [4:0] waddr);
        ex_valid_i        = valid;
        ex_mem_rd_i       = rd;
        ex_mem_wr_i       = wr;
        ex_mem_size_i     = size;
        ex_mem_unsigned_i = uns;
        ex_op_c_i         = opc;
        ex_mem_wdata_i    = wdata;
        ex_reg_waddr_i    = waddr;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    function automatic int sizeBytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : ((size == 2'd1) ? 2 : 4);
    endfunction

    // Return-data formatting, expressed arithmetically on the byte offset.
    function automatic logic [31:0] formatLoad(input logic [31:0] rdata, input int start,
                                               input int nbytes, input bit uns);
        logic [31:0] mask;
        logic [31:0] v;
        mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
        v = (rdata >> (8 * start)) & mask;
        if (!uns && nbytes < 4 && (((v >> (8 * nbytes - 1)) & 32'h1) == 32'h1))
            v = v | ~mask;
        return v;
    endfunction

    // Reference model: evaluates every cycle at the falling edge and
    // compares all outputs against the model's prediction.
    initial begin : model
        forever begin
            logic        e_req, e_we, e_stall, e_mis;
            logic [31:0] e_addr, e_wdata, e_opc;
            logic [3:0]  e_be;
            logic [4:0]  e_waddr;
            int          nb, off, start;
            bit          acc, ld, mis;
            @(negedge clk);
            e_req = 0; e_we = 0; e_stall = 0; e_mis = 0;
            e_addr = 0; e_wdata = 0; e_be = 0;
            e_opc = ex_op_c_i;
            e_waddr = ex_valid_i ? ex_reg_waddr_i : 5'd0;
            nb = sizeBytes(ex_mem_size_i);
            off = int'(ex_op_c_i % 4);
            start = (off / nb) * nb;
            acc = ex_valid_i && (ex_mem_rd_i || ex_mem_wr_i);
            ld = ex_mem_rd_i;
`ifdef MEM_MISALIGN_CHK_EN
            mis = acc && ((off % nb) != 0);
`else
            mis = 1'b0;
`endif
            if (!rst_n) begin
                pend = 1'b0;
            end else if (pend) begin
                e_stall = !bus.dbus_rvalid_i;
                if (bus.dbus_rvalid_i) begin
                    e_opc = formatLoad(bus.dbus_rdata_i, p_start, p_nbytes, p_uns);
                    pend = 1'b0;
                end
            end else if (acc && mis) begin
                e_mis = 1;
                e_waddr = 0;
            end else if (acc) begin
                e_req = 1;
                e_we = !ld;
                e_addr = ex_op_c_i - 32'(off);
                e_be = 4'(((1 << nb) - 1) << start);
                for (int i = 0; i < 4; i++)
                    e_wdata[8*i +: 8] = 8'((ex_mem_wdata_i >> (8 * (i % nb))) & 32'hFF);
                e_stall = ld ? 1'b1 : !bus.dbus_gnt_i;
                if (ld && bus.dbus_gnt_i) begin
                    pend = 1'b1;
                    p_start = start;
                    p_nbytes = nb;
                    p_uns = ex_mem_unsigned_i;
                end
            end
            checkOutput("req",      32'(bus.dbus_req_o),   32'(e_req));
            checkOutput("we",       32'(bus.dbus_we_o),    32'(e_we));
            checkOutput("addr",     bus.dbus_addr_o,       e_addr);
            checkOutput("be",       32'(bus.dbus_be_o),    32'(e_be));
            checkOutput("wdata",    bus.dbus_wdata_o,      e_wdata);
            checkOutput("stall",    32'(mem_stall_o),      32'(e_stall));
            checkOutput("misalign", 32'(mem_misalign_o),   32'(e_mis));
            checkOutput("op_c",     mem_op_c_o,            e_opc);
            checkOutput("waddr",    32'(mem_reg_waddr_o),  32'(e_waddr));
        end
    end

    // Directed scenarios with literal expectations, followed by randomized
    // traffic that follows the protocol (EX is held while stalled).
    initial begin : stim
        int reqs, stalls, rst_cnt;
        bit hold;
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0);
        bus.dbus_gnt_i = 1'b0;
        bus.dbus_rvalid_i = 1'b0;
        bus.dbus_rdata_i = 32'h0;

        // Reset state, with a would-be store on the inputs
        settle();
        applyStimulus(1, 0, 1, 2'b10, 0, 32'h44, 32'h1, 5'd5);
        settle();
        checkOutput("rst_req",   32'(bus.dbus_req_o), 32'h0);
        checkOutput("rst_stall", 32'(mem_stall_o),    32'h0);
        checkOutput("rst_waddr", 32'(mem_reg_waddr_o), 32'd5);
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0);

        // ALU-only pass-through
        nextCycle();
        applyStimulus(1, 0, 0, 2'b10, 0, 32'h55, 32'h0, 5'd7);
        settle();
        checkOutput("alu_opc",   mem_op_c_o,            32'h55);
        checkOutput("alu_waddr", 32'(mem_reg_waddr_o),  32'd7);
        checkOutput("alu_req",   32'(bus.dbus_req_o),   32'h0);
        checkOutput("alu_stall", 32'(mem_stall_o),      32'h0);

        // Word store granted after two wait cycles
        reqs = 0;
        stalls = 0;
        for (int c = 0; c < 4; c++) begin
            nextCycle();
            if (c < 3) applyStimulus(1, 0, 1, 2'b10, 0, 32'h1004, 32'hDEADBEEF, 5'd0);
            else       applyStimulus(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0);
            bus.dbus_gnt_i = (c == 2);
            settle();
            reqs += int'(bus.dbus_req_o);
            stalls += int'(mem_stall_o);
            if (c == 0) begin
                checkOutput("st_be",    32'(bus.dbus_be_o), 32'hF);
                checkOutput("st_addr",  bus.dbus_addr_o,    32'h1004);
                checkOutput("st_wdata", bus.dbus_wdata_o,   32'hDEADBEEF);
                checkOutput("st_we",    32'(bus.dbus_we_o), 32'h1);
            end
        end
        checkOutput("st_req_cycles",   32'(reqs),   32'd3);
        checkOutput("st_stall_cycles", 32'(stalls), 32'd2);

        // Signed byte load at 0x2003, immediate grant, data three cycles later
        nextCycle();
        applyStimulus(1, 1, 0, 2'b00, 0, 32'h2003, 32'h0, 5'd9);
        bus.dbus_gnt_i = 1'b1;
        settle();
        checkOutput("lb_be",    32'(bus.dbus_be_o), 32'h8);
        checkOutput("lb_addr",  bus.dbus_addr_o,    32'h2000);
        checkOutput("lb_stall", 32'(mem_stall_o),   32'h1);
        for (int c = 0; c < 2; c++) begin
            nextCycle();
            bus.dbus_gnt_i = 1'b0;
            settle();
            checkOutput("lb_wait_stall", 32'(mem_stall_o),    32'h1);
            checkOutput("lb_wait_req",   32'(bus.dbus_req_o), 32'h0);
        end
        nextCycle();
        bus.dbus_rvalid_i = 1'b1;
        bus.dbus_rdata_i = 32'h80ABCDEF;
        settle();
        checkOutput("lb_data",     mem_op_c_o,          32'hFFFFFF80);
        checkOutput("lb_stall_rv", 32'(mem_stall_o),    32'h0);
        nextCycle();
        bus.dbus_rvalid_i = 1'b0;
        applyStimulus(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0);

        // Unsigned half load at 0x2002
        nextCycle();
        applyStimulus(1, 1, 0, 2'b01, 1, 32'h2002, 32'h0, 5'd3);
        bus.dbus_gnt_i = 1'b1;
        settle();
        checkOutput("lhu_be", 32'(bus.dbus_be_o), 32'hC);
        nextCycle();
        bus.dbus_gnt_i = 1'b0;
        bus.dbus_rvalid_i = 1'b1;
        bus.dbus_rdata_i = 32'hBEEF1234;
        settle();
        checkOutput("lhu_data", mem_op_c_o, 32'h0000BEEF);
        nextCycle();
        bus.dbus_rvalid_i = 1'b0;
        applyStimulus(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0);

        // Reset while a load is waiting for data, then a late rvalid
        nextCycle();
        applyStimulus(1, 1, 0, 2'b10, 0, 32'h4000, 32'h0, 5'd4);
        bus.dbus_gnt_i = 1'b1;
        nextCycle();
        bus.dbus_gnt_i = 1'b0;
        rst_n = 1'b0;
        settle();
        checkOutput("rstw_stall", 32'(mem_stall_o), 32'h0);
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 2'b00, 0, 32'h12345678, 32'h0, 5'd0);
        bus.dbus_rvalid_i = 1'b1;
        bus.dbus_rdata_i = 32'hFFFFFFFF;
        settle();
        checkOutput("rstw_late_stall", 32'(mem_stall_o), 32'h0);
        checkOutput("rstw_late_opc",   mem_op_c_o,       32'h12345678);
        nextCycle();
        bus.dbus_rvalid_i = 1'b0;

        // Misaligned word load at 0x3002
        nextCycle();
        applyStimulus(1, 1, 0, 2'b10, 0, 32'h3002, 32'h0, 5'd11);
        settle();
`ifdef MEM_MISALIGN_CHK_EN
        checkOutput("mis_req",   32'(bus.dbus_req_o),  32'h0);
        checkOutput("mis_flag",  32'(mem_misalign_o),  32'h1);
        checkOutput("mis_waddr", 32'(mem_reg_waddr_o), 32'h0);
        checkOutput("mis_stall", 32'(mem_stall_o),     32'h0);
`else
        checkOutput("mis_req",  32'(bus.dbus_req_o),  32'h1);
        checkOutput("mis_addr", bus.dbus_addr_o,      32'h3000);
        checkOutput("mis_be",   32'(bus.dbus_be_o),   32'hF);
        checkOutput("mis_flag", 32'(mem_misalign_o),  32'h0);
        nextCycle();
        bus.dbus_gnt_i = 1'b1;
        nextCycle();
        bus.dbus_gnt_i = 1'b0;
        bus.dbus_rvalid_i = 1'b1;
        bus.dbus_rdata_i = 32'hCAFEF00D;
        settle();
        checkOutput("mis_data", mem_op_c_o, 32'hCAFEF00D);
        nextCycle();
        bus.dbus_rvalid_i = 1'b0;
`endif
        nextCycle();
        applyStimulus(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0);

        // Randomized traffic; the model process checks every cycle
        rst_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            hold = mem_stall_o;
            nextCycle();
            if (rst_cnt > 0) begin
                rst_cnt--;
                if (rst_cnt == 0) rst_n = 1'b1;
            end else if ($urandom_range(99) == 0) begin
                rst_n = 1'b0;
                rst_cnt = 1 + int'($urandom_range(1));
            end
            if (!hold) begin
                int kind;
                kind = int'($urandom_range(3));
                applyStimulus($urandom_range(3) != 0, (kind == 1) || (kind == 3),
                              (kind == 2) || (kind == 3), 2'($urandom_range(3)),
                              1'($urandom_range(1)), $urandom, $urandom,
                              5'($urandom_range(31)));
            end
            bus.dbus_gnt_i = 1'($urandom_range(1));
            bus.dbus_rvalid_i = ($urandom_range(4) < 2);
            bus.dbus_rdata_i = $urandom;
        end

        rst_n = 1'b1;
        nextCycle();
        settle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk  in  1  clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  async active-low reset.
REQ-003 SHALL have ports: ex_valid_i  in  1  instruction present; ex_op_c_i  in  32  ALU result / effective address; ex_reg_waddr_i  in  5  destination register; ex_mem_rd_i  in  1  load; ex_mem_wr_i  in  1  store; ex_mem_size_i  in  2  00 byte, 01 half, 10 word, 11 treated as word; ex_mem_unsigned_i  in  1  zero-extend load; ex_mem_wdata_i  in  32  store data.
REQ-004 SHALL have ports: dbus_req_o  out  1; dbus_we_o  out  1; dbus_addr_o  out  32  word-aligned; dbus_be_o  out  4; dbus_wdata_o  out  32; dbus_gnt_i  in  1  request accepted; dbus_rvalid_i  in  1  read data valid; dbus_rdata_i  in  32.
REQ-005 SHALL have ports: mem_op_c_o  out  32  result to MEM/WB register; mem_reg_waddr_o  out  5; mem_stall_o  out  1  freeze upstream and MEM/WB; mem_misalign_o  out  1.

Function
REQ-006 SHALL implement FSM states IDLE, WAIT; IDLE on reset.
REQ-007 Access = ex_valid_i & (ex_mem_rd_i | ex_mem_wr_i); rd and wr both high SHALL be treated as load.
REQ-008 IDLE with access SHALL assert dbus_req_o combinationally same cycle; dbus_we_o = store; dbus_addr_o = {ex_op_c_i[31:2], 2'b00}.
REQ-009 dbus_be_o: byte 4'b0001 << addr[1:0]; half 4'b0011 << {addr[1],1'b0}; word 4'b1111; 0 when no request.
REQ-010 dbus_wdata_o: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-011 dbus_req_o and its address/be/data SHALL remain stable until dbus_gnt_i sampled high.
REQ-012 Store: completes in cycle of gnt; mem_stall_o = dbus_req_o & ~dbus_gnt_i; FSM stays IDLE.
REQ-013 Load: gnt in IDLE -> WAIT; mem_stall_o=1 in IDLE during load regardless of gnt; in WAIT mem_stall_o = ~dbus_rvalid_i; rvalid in WAIT -> IDLE.
REQ-014 At gnt of a load SHALL register addr[1:0], size, unsigned; WAIT formatting SHALL use registered copies only.
REQ-015 Load result: select byte/half lane by registered offset, sign- or zero-extend to 32 bits; word passes through.
REQ-016 mem_op_c_o = formatted load data when WAIT & dbus_rvalid_i, else ex_op_c_i; mem_reg_waddr_o = ex_reg_waddr_i when ex_valid_i, else 0.
REQ-017 dbus_req_o SHALL be 0 in WAIT (one outstanding transaction max).
REQ-018 dbus_rvalid_i in IDLE SHALL be ignored.
REQ-019 Non-access valid instruction SHALL pass through with zero latency, mem_stall_o=0.

Reset
REQ-020 rst_n low SHALL force FSM IDLE, registered offset/size/unsigned to 0, immediately and asynchronously.
REQ-021 Reset mid-load (WAIT) SHALL abandon the transaction; late rvalid after reset ignored per REQ-018.
REQ-022 During reset all outputs SHALL be 0 except mem_op_c_o/mem_reg_waddr_o which follow REQ-016 with FSM IDLE.

Configuration
REQ-023 Macro MEM_MISALIGN_CHK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL suppress dbus_req_o, assert mem_misalign_o for that cycle, mem_stall_o=0, mem_reg_waddr_o=0.
REQ-024 Macro undefined: mem_misalign_o tied 0; offset bits below access size ignored (half uses addr[1], word uses none).

Verification
REQ-025 Word store addr 0x1004 data 0xDEADBEEF, gnt after 2 cycles -> req 3 cycles, be 4'b1111, stall 2 cycles, FSM stays IDLE.
REQ-026 Byte load signed addr 0x2003, gnt immediate, rvalid 3 cycles later rdata 0x80xxxxxx -> be 4'b1000, mem_op_c_o 0xFFFFFF80 in rvalid cycle, stall drops same cycle.
REQ-027 Half load unsigned addr 0x2002, rdata 0xBEEF1234 -> mem_op_c_o 0x0000BEEF.
REQ-028 rst_n low while in WAIT, then rvalid=1 after release -> FSM IDLE, rvalid ignored, no stall.
REQ-029 With MEM_MISALIGN_CHK_EN, word load addr 0x3002 -> dbus_req_o 0, mem_misalign_o 1, mem_reg_waddr_o 0; without macro -> request addr 0x3000, be 4'b1111.
REQ-030 ALU-only instruction op_c 0x55, waddr 7 -> mem_op_c_o 0x55, mem_reg_waddr_o 7, no request, stall 0.
